// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART transmitter between NREQ word producers
// Grants one requester at a time and sends optional header plus the word LSB-byte-first, paced on TxD_busy.
module uart_tx_scheduler #(
    parameter int NREQ       = 4,
    parameter int WORD_BYTES = 4,
    parameter int HEADER_EN  = 1,
    parameter int BUSY_TMO   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*WORD_BYTES*8-1:0] req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         TxD_start,
    output logic [7:0]                   TxD_data,
    input  logic                         TxD_busy,
    output logic                         sched_busy,
    output logic [3:0]                   grant_id,
    output logic                         tmo_err
);

    localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW     = WORD_BYTES * 8;
    localparam int NBYTES = WORD_BYTES + ((HEADER_EN != 0) ? 1 : 0);
    localparam int CNT_W  = 4;
    localparam int TMO_W  = $clog2(BUSY_TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   sel_q, sel_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]     shreg_q, shreg_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              sched_busy_q, sched_busy_d;
    logic [3:0]        grant_id_q, grant_id_d;
    logic              tmo_err_q, tmo_err_d;

    logic [NREQ-1:0]   rot;
    logic [ID_W-1:0]   off;
    logic [ID_W:0]     sum;
    logic [ID_W-1:0]   pick_id;
    logic [WW-1:0]     sel_word;
    logic              hdr_phase;
    logic              last_byte;
    logic [7:0]        cur_byte;

    // Rotate valids so bit 0 is rr_ptr; the lowest set bit is the next winner.
    always_comb begin
        rot = NREQ'({req_valid, req_valid} >> rr_ptr_q);
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = ID_W'(k);
            end
        end
        sum = {1'b0, rr_ptr_q} + {1'b0, off};
        if (sum >= (ID_W + 1)'(NREQ)) begin
            sum = sum - (ID_W + 1)'(NREQ);
        end
        pick_id = sum[ID_W-1:0];
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_q == ID_W'(i)) begin
                sel_word = req_data[i*WW +: WW];
            end
        end
    end

    // Header occupies byte slot 0, so the word itself is only shifted after data bytes.
    assign hdr_phase = (HEADER_EN != 0) && (byte_cnt_q == '0);
    assign last_byte = (byte_cnt_q == CNT_W'(NBYTES - 1));
    assign cur_byte  = hdr_phase ? {4'hA, grant_id_q} : shreg_q[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            rr_ptr_q     <= '0;
            shreg_q      <= '0;
            byte_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            tx_data_q    <= '0;
            sched_busy_q <= 1'b0;
            grant_id_q   <= '0;
            tmo_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rr_ptr_q     <= rr_ptr_d;
            shreg_q      <= shreg_d;
            byte_cnt_q   <= byte_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tx_data_q    <= tx_data_d;
            sched_busy_q <= sched_busy_d;
            grant_id_q   <= grant_id_d;
            tmo_err_q    <= tmo_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        rr_ptr_d     = rr_ptr_q;
        shreg_d      = shreg_q;
        byte_cnt_d   = byte_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        tx_data_d    = tx_data_q;
        sched_busy_d = sched_busy_q;
        grant_id_d   = grant_id_q;
        tmo_err_d    = tmo_err_q;
        req_ready    = '0;
        TxD_start    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    sel_d   = pick_id;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                for (int i = 0; i < NREQ; i++) begin
                    req_ready[i] = (sel_q == ID_W'(i));
                end
                shreg_d      = sel_word;
                grant_id_d   = 4'(sel_q);
                rr_ptr_d     = (sel_q == ID_W'(NREQ - 1)) ? '0 : sel_q + ID_W'(1);
                byte_cnt_d   = '0;
                sched_busy_d = 1'b1;
                state_d      = S_START;
            end
            S_START: begin
                if (!TxD_busy) begin
                    TxD_start = 1'b1;
                    tx_data_d = cur_byte;
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (TxD_busy) begin
                    state_d = S_WAIT_LO;
                end else if (tmo_cnt_q == TMO_W'(BUSY_TMO - 1)) begin
                    tmo_err_d    = 1'b1;
                    sched_busy_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (!TxD_busy) begin
                    if (last_byte) begin
                        sched_busy_d = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        if (!hdr_phase) begin
                            shreg_d = shreg_q >> 8;
                        end
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        state_d    = S_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered copy holds the byte steady for the whole frame.
        TxD_data = TxD_start ? cur_byte : tx_data_q;
    end

    assign sched_busy = sched_busy_q;
    assign grant_id   = grant_id_q;
    assign tmo_err    = tmo_err_q;

endmodule
